bin_to_disp: RTL and testbench

BIN_TO_DISP -- requirements
Module: bin_to_disp

---
 rtl/bin_to_disp.sv | 145 ++++++++++++++
 tb/tb_bin_to_disp.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bin_to_disp.sv
// Sequential 14-bit binary to 4-digit BCD display driver (double dabble, one bit per cycle).
// Optional macro LEADING_ZERO_BLANK_EN enables leading-zero blanking bounded by the decimal point.
module bin_to_disp (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [13:0] i_bin,
  input  logic        i_err_in,
  input  logic [3:0]  i_dp_in,
  output logic [3:0]  o_dig0,
  output logic [3:0]  o_dig1,
  output logic [3:0]  o_dig2,
  output logic [3:0]  o_dig3,
  output logic [3:0]  o_err,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_blank,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FIN} state_t;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] RST_BLANK = 4'b1110;
`else
  localparam logic [3:0] RST_BLANK = 4'b0000;
`endif

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [13:0] r_bin, r_shift;
  logic        r_err_in;
  logic [3:0]  r_dp_in;
  logic [15:0] r_acc;
  logic [15:0] w_adj, w_step;
  logic        w_accept, w_bad;
  logic [3:0]  w_blank;

  logic [3:0]  r_dig0, r_dig1, r_dig2, r_dig3;
  logic [3:0]  r_err, r_dp, r_blank;
  logic        r_busy, r_done;

  // busy is the state delayed by one cycle, so the done cycle still counts as busy
  assign w_accept = (r_state == S_IDLE) && i_start && !r_busy;

  // NOTE: state registers use <=; combinational blocks use = with every output defaulted first so no latch is inferred.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CONV;
      S_CONV:  if (r_cnt == 4'd13) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 4; i++) begin
      if (r_acc[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
    end
    w_step = {w_adj[14:0], r_shift[13]};
  end

  always_comb begin
    logic run;
    run     = 1'b1;
    w_blank = 4'b0000;
    w_bad   = r_err_in || (r_bin > 14'd9999);
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      run        = run && (r_acc[i*4 +: 4] == 4'd0) && !r_dp_in[i];
      w_blank[i] = run;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_bin    <= '0;
      r_shift  <= '0;
      r_err_in <= 1'b0;
      r_dp_in  <= '0;
      r_acc    <= '0;
      r_dig0   <= '0;
      r_dig1   <= '0;
      r_dig2   <= '0;
      r_dig3   <= '0;
      r_err    <= '0;
      r_dp     <= '0;
      r_blank  <= RST_BLANK;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE);
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_bin    <= i_bin;
          r_shift  <= i_bin;
          r_err_in <= i_err_in;
          r_dp_in  <= i_dp_in;
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        S_CONV: begin
          r_acc   <= w_step;
          r_shift <= {r_shift[12:0], 1'b0};
          r_cnt   <= r_cnt + 4'd1;
        end
        S_FIN: begin
          if (w_bad) begin
            {r_dig3, r_dig2, r_dig1, r_dig0} <= '0;
            r_err   <= 4'b1111;
            r_dp    <= 4'b0000;
            r_blank <= 4'b0000;
          end else begin
            {r_dig3, r_dig2, r_dig1, r_dig0} <= r_acc;
            r_err   <= 4'b0000;
            r_dp    <= r_dp_in;
            r_blank <= w_blank;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dig0  = r_dig0;
  assign o_dig1  = r_dig1;
  assign o_dig2  = r_dig2;
  assign o_dig3  = r_dig3;
  assign o_err   = r_err;
  assign o_dp    = r_dp;
  assign o_blank = r_blank;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_bin_to_disp.sv
// Randomized and directed bench for bin_to_disp against a decimal-arithmetic reference model.
module tb_bin_to_disp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [13:0] i_bin = '0;
  logic        i_err_in = 1'b0;
  logic [3:0]  i_dp_in = '0;
  logic [3:0]  o_dig0, o_dig1, o_dig2, o_dig3, o_err, o_dp, o_blank;
  logic        o_busy, o_done;

  int checks = 0;
  int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] RST_BLANK = 4'b1110;
  localparam bit LZB = 1'b1;
`else
  localparam logic [3:0] RST_BLANK = 4'b0000;
  localparam bit LZB = 1'b0;
`endif

  logic [15:0] exp_digs;
  logic [3:0]  exp_err, exp_dp, exp_blank;

  bin_to_disp dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_bin(i_bin), .i_err_in(i_err_in),
    .i_dp_in(i_dp_in), .o_dig0(o_dig0), .o_dig1(o_dig1), .o_dig2(o_dig2), .o_dig3(o_dig3),
    .o_err(o_err), .o_dp(o_dp), .o_blank(o_blank), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_digs  = '0;
    exp_err   = '0;
    exp_dp    = '0;
    exp_blank = RST_BLANK;
  endtask

  // Expected display from decimal arithmetic on the value
  task automatic model_convert(input int v, input bit e, input logic [3:0] dp);
    int pow10 [4] = '{1, 10, 100, 1000};
    if (e || v > 9999) begin
      exp_digs  = '0;
      exp_err   = 4'b1111;
      exp_dp    = 4'b0000;
      exp_blank = 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) exp_digs[i*4 +: 4] = 4'((v / pow10[i]) % 10);
      exp_err   = 4'b0000;
      exp_dp    = dp;
      exp_blank = 4'b0000;
      for (int i = 1; i < 4; i++)
        exp_blank[i] = LZB && (v < pow10[i]) && ((dp >> i) == 4'd0);
    end
  endtask

  task automatic check_display(input string tag);
    check({tag, "_digits"}, {16'd0, o_dig3, o_dig2, o_dig1, o_dig0}, {16'd0, exp_digs});
    check({tag, "_err"},    {28'd0, o_err},   {28'd0, exp_err});
    check({tag, "_dp"},     {28'd0, o_dp},    {28'd0, exp_dp});
    check({tag, "_blank"},  {28'd0, o_blank}, {28'd0, exp_blank});
  endtask

  // Called just after a clock edge with the DUT idle; the next edge is edge k.
  // poke_c >= 0 raises a second start (bin=1) right after edge k+poke_c.
  task automatic run_conv(input int v, input bit e, input logic [3:0] dp, input int poke_c);
    i_start = 1'b1; i_bin = 14'(v); i_err_in = e; i_dp_in = dp;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("busy_k", {31'd0, o_busy}, 32'd0);
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      if (c == 15) model_convert(v, e, dp);
      check($sformatf("done_c%0d", c), {31'd0, o_done}, {31'd0, c == 15});
      check($sformatf("busy_c%0d", c), {31'd0, o_busy}, {31'd0, c <= 15});
      if (c == 14 || c == 15) check_display($sformatf("disp_c%0d", c));
      if (c == poke_c) begin
        i_start = 1'b1; i_bin = 14'd1; i_err_in = 1'b0; i_dp_in = 4'd0;
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1; i_start = 1'b1; i_bin = 14'd1234;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check_display("rst");
    i_start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check("rst_prio_busy", {31'd0, o_busy}, 32'd0);

    run_conv(1234, 1'b0, 4'b0000, -1);
    run_conv(7,    1'b0, 4'b0000, -1);
    run_conv(10000, 1'b0, 4'b0000, -1);
    run_conv(5,    1'b1, 4'b0011, -1);
    run_conv(5,    1'b0, 4'b0100, -1);
    run_conv(0,    1'b0, 4'b0000, -1);
    run_conv(16383, 1'b0, 4'b1111, -1);
    // second start mid-conversion and during the done cycle must be ignored
    run_conv(9999, 1'b0, 4'b0000, 5);
    run_conv(9999, 1'b0, 4'b0010, 15);
    run_conv(1,    1'b0, 4'b0000, -1);

    for (int n = 0; n < 30; n++) begin
      int v;
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9990, 16383))
                                      : int'($urandom_range(0, 9999));
      run_conv(v, ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), -1);
    end

    // reset mid-conversion aborts with no done pulse
    i_start = 1'b1; i_bin = 14'd4321; i_err_in = 1'b0; i_dp_in = 4'd0;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_done", {31'd0, o_done}, 32'd0);
    check_display("abort");
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check($sformatf("abort_nodone_%0d", c), {31'd0, o_done}, 32'd0);
    end
    run_conv(4321, 1'b0, 4'b0000, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
